// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 32-bit word RAM between the instruction
// fetch port and the load/store data port. Sub-word stores are done as a
// read-modify-write. Arbitration happens only in IDLE, and ties go round-robin.
// Optional build macro: RAM_ARB_MISALIGN_TRAP_EN. When it is defined, misaligned
// accesses skip the RAM and are acknowledged with d_err set.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RAM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_wen,
    output logic              ram_ren,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [RAM_AW-1:0] ram_raddr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RMW_RD, S_RMW_MERGE, S_RMW_WR, S_ACK
    } state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } port_t;

    state_t            state_q, state_d;
    port_t             last_grant_q;
    port_t             owner_q;
    logic [RAM_AW-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       merged_d;
    logic [31:0]       f_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              err_q;
    logic              grant_f, grant_d;
    logic              f_mis, d_mis;

`ifdef RAM_ARB_MISALIGN_TRAP_EN
    // Word accesses need addr[1:0]==0, and halfword stores need addr[0]==0.
    function automatic logic d_misaligned(input logic we, input logic [3:0] be,
                                          input logic [1:0] lo);
        if (!we || be == 4'hF) return lo != 2'b00;
        if (be == 4'h3 || be == 4'hC) return lo[0];
        return 1'b0;
    endfunction

    assign f_mis = (f_addr[1:0] != 2'b00);
    assign d_mis = d_misaligned(d_we, d_be, d_addr[1:0]);
`else
    logic unused_addr_lo;
    assign f_mis = 1'b0;
    assign d_mis = 1'b0;
    assign unused_addr_lo = ^{f_addr[1:0], d_addr[1:0]};
`endif

    // Arbitration: grants only in IDLE. On a tie, the port that did not win last time gets the grant.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            if (f_req && d_req) begin
                if (last_grant_q == GNT_FETCH) grant_d = 1'b1;
                else                           grant_f = 1'b1;
            end else begin
                grant_f = f_req;
                grant_d = d_req;
            end
        end
    end

    // Next-state logic: the access type is decoded from the live inputs at grant time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_f) begin
                    state_d = f_mis ? S_ACK : S_RD;
                end else if (grant_d) begin
                    if (d_mis)               state_d = S_ACK;
                    else if (!d_we)          state_d = S_RD;
                    else if (d_be == 4'hF)   state_d = S_WR;
                    else if (d_be == 4'h0)   state_d = S_ACK;
                    else                     state_d = S_RMW_RD;
                end
            end
            S_RD:        state_d = S_RD_WAIT;
            S_RD_WAIT:   state_d = S_ACK;
            S_WR:        state_d = S_ACK;
            S_RMW_RD:    state_d = S_RMW_MERGE;
            S_RMW_MERGE: state_d = S_RMW_WR;
            S_RMW_WR:    state_d = S_ACK;
            S_ACK:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Byte-lane merge of the store data over the word just read back from the RAM.
    always_comb begin
        merged_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
        end
    end

    // State register and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_FETCH;
        end else begin
            state_q <= state_d;
            if (grant_f)      last_grant_q <= GNT_FETCH;
            else if (grant_d) last_grant_q <= GNT_DATA;
        end
    end

    // Latch the request on grant, and hold the merged word for the write-back cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= GNT_FETCH;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merged_q <= '0;
        end else begin
            if (grant_f) begin
                owner_q <= GNT_FETCH;
                addr_q  <= f_addr[ADDR_W-1:2];
                be_q    <= '0;
                wdata_q <= '0;
                err_q   <= 1'b0;
            end else if (grant_d) begin
                owner_q <= GNT_DATA;
                addr_q  <= d_addr[ADDR_W-1:2];
                be_q    <= d_be;
                wdata_q <= d_wdata;
                err_q   <= d_mis;
            end
            if (state_q == S_RMW_MERGE) merged_q <= merged_d;
        end
    end

    // Read-data registers: loaded in RD_WAIT and cleared when a trapped access is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant_f && f_mis) f_rdata_q <= '0;
            if (grant_d && d_mis) d_rdata_q <= '0;
            if (state_q == S_RD_WAIT) begin
                if (owner_q == GNT_FETCH) f_rdata_q <= ram_rdata;
                else                      d_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM and handshake outputs decode from the state. Address and data are zeroed when the RAM is not in use.
    always_comb begin
        ram_ren   = (state_q == S_RD) || (state_q == S_RMW_RD);
        ram_wen   = (state_q == S_WR) || (state_q == S_RMW_WR);
        ram_raddr = ram_ren ? addr_q : '0;
        ram_waddr = ram_wen ? addr_q : '0;
        ram_wdata = '0;
        if (state_q == S_WR)     ram_wdata = wdata_q;
        if (state_q == S_RMW_WR) ram_wdata = merged_q;
        f_gnt     = grant_f;
        d_gnt     = grant_d;
        f_rvalid  = (state_q == S_ACK) && (owner_q == GNT_FETCH);
        d_rvalid  = (state_q == S_ACK) && (owner_q == GNT_DATA);
        d_err     = d_rvalid && err_q;
        f_rdata   = f_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter, with a behavioural 1-cycle-read RAM model.
module tb_ram_arbiter;

    logic        clk, rst;
    logic        f_req, f_gnt, f_rvalid;
    logic [15:0] f_addr;
    logic [31:0] f_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [15:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        ram_wen, ram_ren;
    logic [13:0] ram_waddr, ram_raddr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:16383];
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;
    int both_seen = 0;
    logic saw_wen, saw_rv;

    ram_arbiter #(.ADDR_W(16), .RAM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    always @(negedge clk) begin
        if (ram_wen && ram_ren) both_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] v);
        pre_addr = a;
        pre_data = v;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        ram_rdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        rst = 1'b1;
        f_req = 1'b1; f_addr = 16'h0014;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 16'h0014; d_wdata = '0;
        #1;
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_ram_en", {ram_wen, ram_ren}, 0);
        chk("rst_rvalid", {f_rvalid, d_rvalid, d_err}, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_ram_addr", {ram_waddr, ram_raddr}, 0);
        f_req = 1'b0; d_req = 1'b0;
        tick();
        rst = 1'b0;
        preload(14'd5, 32'hDEADBEEF);
        preload(14'd2, 32'h11223344);
        preload(14'd4, 32'h55667788);
        preload(14'h3FFF, 32'h0BADF00D);

        // Tie right after reset: data wins.
        tick();
        f_req = 1'b1; f_addr = 16'h0014;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0014;
        #1;
        chk("tie1_d_gnt", d_gnt, 1);
        chk("tie1_f_gnt", f_gnt, 0);
        tick(); d_req = 1'b0; #1;            // T+1
        chk("tie1_ren", ram_ren, 1);
        chk("tie1_raddr", ram_raddr, 5);
        chk("tie1_f_wait", f_gnt, 0);
        tick(); #1;                          // T+2
        chk("tie1_no_early_rv", d_rvalid, 0);
        tick(); #1;                          // T+3
        chk("tie1_d_rvalid", d_rvalid, 1);
        chk("tie1_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("tie1_f_still_wait", f_gnt, 0);
        // Second tie: fetch wins this time.
        tick(); d_req = 1'b1; d_addr = 16'h0008; #1;   // T+4
        chk("tie2_f_gnt", f_gnt, 1);
        chk("tie2_d_gnt", d_gnt, 0);
        tick(); f_req = 1'b0; #1;            // T+5
        chk("tie2_ren", ram_ren, 1);
        chk("tie2_d_wait", d_gnt, 0);
        tick(); tick(); #1;                  // T+7
        chk("tie2_f_rvalid", f_rvalid, 1);
        chk("tie2_f_rdata", f_rdata, 32'hDEADBEEF);
        chk("tie2_d_rv_low", d_rvalid, 0);
        tick(); #1;                          // T+8
        chk("tie2_d_gnt_late", d_gnt, 1);
        tick(); d_req = 1'b0; tick(); tick(); #1;   // T+11
        chk("tie2_d_rvalid", d_rvalid, 1);
        chk("tie2_d_rdata", d_rdata, 32'h11223344);

        // Fetch at the top word: tests that the word address wraps.
        tick(); f_req = 1'b1; f_addr = 16'hFFFC; #1;
        chk("wrap_f_gnt", f_gnt, 1);
        tick(); f_req = 1'b0; #1;
        chk("wrap_ren", ram_ren, 1);
        chk("wrap_raddr", ram_raddr, 14'h3FFF);
        chk("wrap_wen", ram_wen, 0);
        tick(); #1;
        chk("wrap_idle_raddr", {ram_ren, ram_raddr}, 0);
        tick(); #1;
        chk("wrap_f_rvalid", f_rvalid, 1);
        chk("wrap_f_rdata", f_rdata, 32'h0BADF00D);

        // Partial store, byte lane 1 of word 2.
        tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_wdata = 32'h0000AA00; d_addr = 16'h0008; #1;
        chk("rmw_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;            // T+1
        chk("rmw_ren", ram_ren, 1);
        chk("rmw_raddr", ram_raddr, 2);
        tick(); #1;                          // T+2
        chk("rmw_merge_quiet", {ram_wen, ram_ren}, 0);
        tick(); #1;                          // T+3
        chk("rmw_wen", ram_wen, 1);
        chk("rmw_waddr", ram_waddr, 2);
        chk("rmw_wdata", ram_wdata, 32'h1122AA44);
        tick(); #1;                          // T+4
        chk("rmw_d_rvalid", d_rvalid, 1);
        chk("rmw_d_rdata_kept", d_rdata, 32'h11223344);
        chk("rmw_ack_wdata", ram_wdata, 0);
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0008; #1;
        chk("rmw_ld_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; tick(); tick(); #1;
        chk("rmw_ld_rvalid", d_rvalid, 1);
        chk("rmw_ld_rdata", d_rdata, 32'h1122AA44);

        // Full store to word 3.
        tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hCAFEF00D; d_addr = 16'h000C; #1;
        chk("full_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        chk("full_wen", ram_wen, 1);
        chk("full_ren", ram_ren, 0);
        chk("full_waddr", ram_waddr, 3);
        chk("full_wdata", ram_wdata, 32'hCAFEF00D);
        tick(); #1;
        chk("full_d_rvalid", d_rvalid, 1);
        chk("full_wen_off", ram_wen, 0);

        // Store with no byte enables: acknowledged without a RAM access.
        tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_wdata = 32'hFFFFFFFF; d_addr = 16'h000C; #1;
        chk("be0_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        chk("be0_d_rvalid", d_rvalid, 1);
        chk("be0_no_ram", {ram_wen, ram_ren}, 0);
        tick(); #1;
        chk("be0_rvalid_pulse", d_rvalid, 0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h000C; #1;
        chk("be0_ld_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; tick(); tick(); #1;
        chk("be0_ld_rdata", d_rdata, 32'hCAFEF00D);

`ifdef RAM_ARB_MISALIGN_TRAP_EN
        // Misaligned load traps.
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0006; #1;
        chk("mis_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        chk("mis_no_ren", ram_ren, 0);
        chk("mis_d_rvalid", d_rvalid, 1);
        chk("mis_d_err", d_err, 1);
        chk("mis_d_rdata", d_rdata, 0);
`else
        // Low address bits are ignored, and d_err stays low.
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0015; #1;
        chk("lo_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        chk("lo_raddr", ram_raddr, 5);
        tick(); tick(); #1;
        chk("lo_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("lo_d_err", {d_rvalid, d_err}, 2'b10);
`endif

        // Reset asserted during RMW_MERGE aborts the store.
        tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_wdata = 32'h000000EE; d_addr = 16'h0010; #1;
        chk("abort_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;            // RMW_RD
        chk("abort_ren", ram_ren, 1);
        tick();                              // RMW_MERGE
        rst = 1'b1; #1;
        chk("abort_ram_off", {ram_wen, ram_ren}, 0);
        chk("abort_no_rv", d_rvalid, 0);
        saw_wen = 1'b0; saw_rv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            rst = 1'b0; #1;
            saw_wen |= ram_wen;
            saw_rv  |= d_rvalid;
        end
        chk("abort_never_wen", saw_wen, 0);
        chk("abort_never_rv", saw_rv, 0);
        chk("abort_mem_kept", mem[4], 32'h55667788);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; #1;
        chk("abort_idle_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; tick(); tick(); #1;
        chk("abort_ld_rdata", d_rdata, 32'h55667788);

        chk("never_wen_and_ren", both_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences the single-port 32-bit word RAM (14-bit word address, 1-cycle registered read, whole-word write only).
- Shares it between the instruction-fetch port (read-only) and the load/store data port.
- Implements byte/halfword stores as a read-modify-write sequence.
- Sits between the CPU core's fetch/LSU interfaces and the RAM instance.

Parameters:
- ADDR_W, 16, byte-address width on requester ports; RAM word address = addr[ADDR_W-1:2].
- RAM_AW, 14, RAM word-address width; must equal ADDR_W-2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request; held until f_gnt
- f_addr  in  ADDR_W  fetch byte address
- f_gnt  out  1  fetch request accepted (combinational, IDLE only)
- f_rvalid  out  1  one-cycle pulse; f_rdata valid
- f_rdata  out  32  fetched word (registered)
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables for stores (bit i selects wdata[8i+7:8i])
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, already lane-aligned
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete
- d_rdata  out  32  load word (registered)
- d_err  out  1  misaligned-access flag, valid with d_rvalid (see Optional Feature)
- ram_wen  out  1  RAM write enable
- ram_ren  out  1  RAM read enable
- ram_waddr  out  RAM_AW  RAM write word address
- ram_raddr  out  RAM_AW  RAM read word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_ren

Behaviour:
- Reset:
  - State is IDLE; last_grant = FETCH.
  - All outputs are 0. rdata registers are cleared.
  - Reset asserted mid-operation aborts the transaction: no rvalid is produced, and ram_wen/ram_ren drop immediately.
- States: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_MERGE, RMW_WR, ACK.
- Arbitration in IDLE only:
  - Single requester wins.
  - Both requesting: grant goes to the port not equal to last_grant (round-robin). After reset, data wins the first tie.
  - gnt is combinational, in the same cycle as req. Address, we, be and wdata are latched on gnt; last_grant is updated.
  - No gnt is issued outside IDLE; req may stay high and waits.
- Read (fetch, or data with d_we=0):
  - IDLE(gnt, cycle T) -> RD: ram_ren=1, ram_raddr=word addr.
  - -> RD_WAIT: capture ram_rdata into port rdata.
  - -> ACK: port rvalid=1 for one cycle (T+3).
  - -> IDLE.
- Full store (d_be=4'hF):
  - IDLE(T) -> WR: ram_wen=1, ram_waddr=word addr, ram_wdata=d_wdata.
  - -> ACK: d_rvalid at T+2.
- Partial store (d_be not 0, not 4'hF):
  - IDLE(T) -> RMW_RD (ren).
  - -> RMW_MERGE: merged = byte-wise select (be ? wdata : ram_rdata), registered.
  - -> RMW_WR: wen=1, ram_wdata=merged.
  - -> ACK: d_rvalid at T+4. d_rdata is unchanged by stores.
- Store with d_be=0: no RAM access; IDLE -> ACK; d_rvalid at T+1.
- ram_wen and ram_ren are never both 1. Outside RD/RMW_RD/WR/RMW_WR, RAM address and data outputs are 0.
- Address bits [1:0] are ignored for RAM addressing. No range check; word addresses wrap modulo 2^RAM_AW.
- ACK -> IDLE always. A new grant is possible in the cycle after ACK, giving back-to-back throughput of one read per 4 cycles.

Optional Feature:
- Macro: RAM_ARB_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned data access is: word access (be=4'hF or load) with addr[1:0]!=0, or halfword be (4'h3/4'hC) with addr[0]=1.
  - Such an access performs no RAM access, goes IDLE -> ACK, and d_rvalid pulses with d_err=1 and d_rdata=0.
  - Fetch with f_addr[1:0]!=0 behaves the same but only suppresses the RAM access (no fetch error port).
- Undefined: d_err is tied 0; low address bits are silently ignored.

Test Plan:
- Fetch read: preload word 5 = 32'hDEADBEEF, f_req with f_addr=16'h0014 -> f_gnt same cycle, ram_ren with ram_raddr=5 at T+1, f_rvalid with f_rdata=32'hDEADBEEF at T+3.
- Simultaneous req after reset: f_req and d_req both high -> d_gnt first. On the next tie, f_gnt. The loser's gnt comes only after the winner's ACK cycle.
- Partial store: word 2 = 32'h11223344, d_we=1, d_be=4'b0010, d_wdata=32'h0000AA00, addr=16'h0008 -> ram_wdata=32'h1122AA44 in RMW_WR, d_rvalid at T+4, subsequent load returns 32'h1122AA44.
- Full store and zero-be store: be=4'hF data 32'hCAFEF00D -> single wen cycle, d_rvalid at T+2. be=0 -> no wen/ren, d_rvalid at T+1.
- Reset mid-RMW: assert rst during RMW_MERGE -> ram_wen never asserted, word unchanged, no d_rvalid, state IDLE.
- With RAM_ARB_MISALIGN_TRAP_EN: load at addr=16'h0006 -> no ram_ren, d_rvalid with d_err=1 and d_rdata=0 at T+1.
